// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// Op codes match the decoder's hi_lo_op encoding.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9,
        OP_MSUB  = 4'd10,
        OP_MSUBU = 4'd11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_ACC
    } state_t;

    localparam int          DIV_CYCLES_DEFAULT = 32;
    localparam logic [31:0] DIVZERO_LO         = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EXE-side request/response bundle for the HI/LO multiply/divide unit.
// master = execute stage, slave = muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        req_ready;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider datapath: one step per enabled cycle.
// load seeds rem=0, quo=dividend; after 32 steps quo/rem hold the result.
module div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [33:0] trial;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        // extra top bit keeps the borrow distinct from a set remainder MSB
        trial = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
        if (load) begin
            rem_d = 32'd0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!trial[33]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: one op at a time, commits HI/LO on completion, flush aborts.
// MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MUL then ACC); otherwise those codes act as NOP.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_STAGES = 2,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = 8;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic               req_ready;
    logic               div_load, div_step;
    logic [31:0]        dvd, dvs, quo, rem;
    logic               mul_signed, mul_sub;
    logic [63:0]        a64, b64, prod, acc;

    div_iter u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (dvd),
        .divisor  (dvs),
        .quo      (quo),
        .rem      (rem)
    );

    // 64x64 multiply of extended operands gives the correct signed or unsigned low 64 bits
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        mul_sub    = (op_q == OP_MSUB) || (op_q == OP_MSUBU);
        a64  = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b64  = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod = a64 * b64;
        acc  = mul_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        req_ready = (state_q == S_IDLE) && !bus.flush;
        dvd = (bus.req_op == OP_DIV) ? abs32(bus.req_src1) : bus.req_src1;
        dvs = (bus.req_op == OP_DIV) ? abs32(bus.req_src2) : bus.req_src2;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    case (bus.req_op)
                        OP_MULT, OP_MULTU
`ifdef MULDIV_MADD_EN
                        , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                        : begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_STAGES - 1);
                            op_d    = bus.req_op;
                            a_d     = bus.req_src1;
                            b_d     = bus.req_src2;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_DIV;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            op_d     = bus.req_op;
                            div_load = 1'b1;
                            q_neg_d  = (bus.req_op == OP_DIV) &&
                                       (bus.req_src1[31] ^ bus.req_src2[31]);
                            r_neg_d  = (bus.req_op == OP_DIV) && bus.req_src1[31];
                        end
                        OP_MTHI: hi_d = bus.req_src1;
                        OP_MTLO: lo_d = bus.req_src1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                        {hi_d, lo_d} = prod;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                lo_d    = q_neg_q ? (32'd0 - quo) : quo;
                hi_d    = r_neg_q ? (32'd0 - rem) : rem;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ACC: begin
                {hi_d, lo_d} = acc;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // flush beats everything, including a commit on this same edge
        if (bus.flush) begin
            state_d  = S_IDLE;
            hi_d     = hi_q;
            lo_d     = lo_q;
            done_d   = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, flush/reset sequences, random ops vs arithmetic model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MS = 2;
    localparam int DC = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_STAGES(MS), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected HI/LO and busy length, straight from the arithmetic definitions.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_i, input logic [31:0] lo_i,
                            output logic [31:0] hi_o, output logic [31:0] lo_o, output int bz);
        longint      sq, sr;
        logic [63:0] p, r64;
        hi_o = hi_i;
        lo_o = lo_i;
        bz   = 0;
        case (op)
            OP_MULT: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                r64 = sq;
                {hi_o, lo_o} = r64;
                bz = MS;
            end
            OP_MULTU: begin
                {hi_o, lo_o} = 64'(a) * 64'(b);
                bz = MS;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    lo_o = a[31] ? 32'd1 : DIVZERO_LO;
                    hi_o = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    lo_o = sq[31:0];
                    hi_o = sr[31:0];
                end
                bz = DC + 1;
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    lo_o = DIVZERO_LO;
                    hi_o = a;
                end else begin
                    lo_o = a / b;
                    hi_o = a % b;
                end
                bz = DC + 1;
            end
            OP_MTHI: hi_o = a;
            OP_MTLO: lo_o = a;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                if (op == OP_MADD || op == OP_MSUB) begin
                    sq = longint'($signed(a)) * longint'($signed(b));
                    p  = sq;
                end else begin
                    p = 64'(a) * 64'(b);
                end
                if (op == OP_MSUB || op == OP_MSUBU) r64 = {hi_i, lo_i} - p;
                else                                 r64 = {hi_i, lo_i} + p;
                {hi_o, lo_o} = r64;
                bz = MS + 1;
            end
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where busy has dropped.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic rdy, output int nbusy, output logic dn);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        #1;
        rdy = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        nbusy = 0;
        @(negedge clk);
        while (bus.busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
        dn = bus.done;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ebusy;
    } vec_t;

    vec_t vt[13];
    logic [3:0] ops [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd7, 4'd0};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rdy, dn;
        int          nb;
        logic [31:0] m_hi, m_lo, e_hi, e_lo;
        int          e_bz;

        vt[0]  = '{OP_MTLO,  32'h1234,      32'd0,        32'd0,        32'h1234,     0};
        vt[1]  = '{OP_MTHI,  32'hABCD,      32'd0,        32'hABCD,     32'h1234,     0};
        vt[2]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MS};
        vt[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC + 1};
        vt[4]  = '{OP_DIVU,  32'd100,       32'd0,        32'd100,      32'hFFFF_FFFF, DC + 1};
        vt[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       32'h8000_0000, DC + 1};
        vt[6]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,       MS};
        vt[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,       32'hFFFF_FFFD, DC + 1};
        vt[8]  = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'd1,       DC + 1};
        vt[9]  = '{4'd7,     32'h5555,      32'h6666,     32'hFFFF_FFF8, 32'd1,       0};
        vt[10] = '{OP_MTHI,  32'd0,         32'd0,        32'd0,        32'd1,        0};
        vt[11] = '{OP_MTLO,  32'd10,        32'd0,        32'd0,        32'd10,       0};
`ifdef MULDIV_MADD_EN
        vt[12] = '{OP_MSUBU, 32'd3,         32'd4,        32'hFFFF_FFFF, 32'hFFFF_FFFE, MS + 1};
`else
        vt[12] = '{OP_MSUBU, 32'd3,         32'd4,        32'd0,        32'd10,       0};
`endif

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_src1  = 32'd0;
        bus.req_src2  = 32'd0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_done",  64'(bus.done), 64'd0);
        chk("rst_hi",    64'(bus.hi),   64'd0);
        chk("rst_lo",    64'(bus.lo),   64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);

        // Each op is issued in the done cycle of the previous one.
        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, rdy, nb, dn);
            chk($sformatf("v%0d_ready", i), 64'(rdy), 64'd1);
            chk($sformatf("v%0d_busy", i),  64'(nb),  64'(vt[i].ebusy));
            chk($sformatf("v%0d_done", i),  64'(dn),  64'(vt[i].ebusy > 0));
            chk($sformatf("v%0d_hi", i),    64'(bus.hi), 64'(vt[i].ehi));
            chk($sformatf("v%0d_lo", i),    64'(bus.lo), 64'(vt[i].elo));
        end
        @(negedge clk);
        chk("done_pulse_width", 64'(bus.done), 64'd0);

        // reset in the middle of a divide
        run_op(OP_MTHI, 32'h77, 32'd0, rdy, nb, dn);
        bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_src1 = 32'd50; bus.req_src2 = 32'd7;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_hi",   64'(bus.hi),   64'd0);
        chk("mid_rst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_done", 64'(bus.done), 64'd0);

        // flush during a divide, then exactly on the commit edge of another
        run_op(OP_MTHI, 32'd5, 32'd0, rdy, nb, dn);
        run_op(OP_MTLO, 32'd6, 32'd0, rdy, nb, dn);
        for (int f = 0; f < 2; f++) begin
            bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_src1 = 32'd10; bus.req_src2 = 32'd3;
            @(posedge clk); #1; bus.req_valid = 1'b0;
            repeat ((f == 0) ? 20 : DC + 1) @(negedge clk);
            chk($sformatf("fl%0d_busy_pre", f), 64'(bus.busy), 64'd1);
            bus.flush = 1'b1;
            @(posedge clk); #1; bus.flush = 1'b0;
            @(negedge clk);
            chk($sformatf("fl%0d_busy", f),  64'(bus.busy),      64'd0);
            chk($sformatf("fl%0d_done", f),  64'(bus.done),      64'd0);
            chk($sformatf("fl%0d_ready", f), 64'(bus.req_ready), 64'd1);
            chk($sformatf("fl%0d_hi", f),    64'(bus.hi),        64'd5);
            chk($sformatf("fl%0d_lo", f),    64'(bus.lo),        64'd6);
            @(negedge clk);
            chk($sformatf("fl%0d_done_late", f), 64'(bus.done), 64'd0);
        end
        bus.flush = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = OP_MTHI; bus.req_src1 = 32'h99;
        #1;
        chk("fl_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1; bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        chk("fl_mthi_hi", 64'(bus.hi), 64'd5);

        // random ops against the model
        m_hi = 32'd5;
        m_lo = 32'd6;
        for (int r = 0; r < 40; r++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 11)];
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            model_op(op, a, b, m_hi, m_lo, e_hi, e_lo, e_bz);
            run_op(op, a, b, rdy, nb, dn);
            chk($sformatf("r%0d_op%0d_ready", r, op), 64'(rdy), 64'd1);
            chk($sformatf("r%0d_op%0d_busy", r, op),  64'(nb),  64'(e_bz));
            chk($sformatf("r%0d_op%0d_done", r, op),  64'(dn),  64'(e_bz > 0));
            chk($sformatf("r%0d_op%0d_hi %0h %0h", r, op, a, b), 64'(bus.hi), 64'(e_hi));
            chk($sformatf("r%0d_op%0d_lo %0h %0h", r, op, a, b), 64'(bus.lo), 64'(e_lo));
            m_hi = e_hi;
            m_lo = e_lo;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
